ucode_sequencer: RTL and testbench

- Two-address microcode sequencer for the CountNoX control unit.
- Holds the state register and a writable control store. Drives the 2-bit condition select to the external 4:1 condition mux, consumes the mux's single-bit result, and loads NST (condition true) or NSF (condition false) as the next state.
- Emits the Moore control word (LD, SH, INC, DN) that steers the count-ones datapath.

---
 rtl/ucode_sequencer.sv | 107 ++++++++++
 tb/tb_ucode_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucode_sequencer.sv
// Two-address microcode sequencer: state register plus writable control store.
// Each enabled cycle loads nst or nsf of the current word depending on the selected condition.
module ucode_sequencer #(
    parameter int ADDR_W = 3,
    parameter int CTRL_W = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           en,
    input  logic                           cond,
    output logic [1:0]                     sel,
    output logic [CTRL_W-1:0]              ctrl,
    output logic [ADDR_W-1:0]              state,
    output logic                           busy,
    input  logic                           wr_en,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [2+2*ADDR_W+CTRL_W-1:0]   wr_data
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] SEL_GO   = 2'b00;
    localparam logic [1:0] SEL_DONE = 2'b01;
    localparam logic [1:0] SEL_AX   = 2'b10;
    localparam logic [1:0] SEL_ONE  = 2'b11;

    typedef struct packed {
        logic [1:0]        sel;
        logic [ADDR_W-1:0] nsf;
        logic [ADDR_W-1:0] nst;
        logic [CTRL_W-1:0] ctrl;
    } uword_t;

    uword_t store [DEPTH];
    uword_t cur;

    // Count-ones program; ctrl bit0 LD, bit1 SH, bit2 INC, bit3 DN.
    function automatic uword_t default_word(input int idx);
        uword_t w;
        w     = '0;
        w.sel = SEL_ONE;
        case (idx)
            0: begin
                w.sel = SEL_GO;
                w.nsf = ADDR_W'(0);
                w.nst = ADDR_W'(1);
            end
            1: begin
                w.nsf     = ADDR_W'(1);
                w.nst     = ADDR_W'(2);
                w.ctrl[0] = 1'b1;
            end
            2: begin
                w.sel = SEL_DONE;
                w.nsf = ADDR_W'(3);
                w.nst = ADDR_W'(5);
            end
            3: begin
                w.sel = SEL_AX;
                w.nsf = ADDR_W'(4);
                w.nst = ADDR_W'(6);
            end
            4: begin
                w.nsf     = ADDR_W'(2);
                w.nst     = ADDR_W'(2);
                w.ctrl[1] = 1'b1;
            end
            5: begin
                w.sel     = SEL_GO;
                w.nsf     = ADDR_W'(0);
                w.nst     = ADDR_W'(5);
                w.ctrl[3] = 1'b1;
            end
            6: begin
                w.nsf     = ADDR_W'(4);
                w.nst     = ADDR_W'(4);
                w.ctrl[2] = 1'b1;
            end
            default: begin
                w.nsf = ADDR_W'(0);
                w.nst = ADDR_W'(0);
            end
        endcase
        return w;
    endfunction

    assign cur   = store[state];
    assign sel   = cur.sel;
    assign ctrl  = cur.ctrl;
    assign busy  = (state != '0);

    // The step decodes the pre-edge word, so a write to the current entry
    // only takes effect on the next visit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= '0;
            for (int i = 0; i < DEPTH; i++)
                store[i] <= default_word(i);
        end else begin
            if (en)
                state <= cond ? cur.nst : cur.nsf;
            if (wr_en)
                store[wr_addr] <= uword_t'(wr_data);
        end
    end

endmodule

// File: tb/tb_ucode_sequencer.sv
// Bench for ucode_sequencer: count-ones datapath around the external condition mux,
// with a lockstep table-driven model of the control store and state.
module tb_ucode_sequencer;

    typedef struct packed {
        logic [1:0] sel;
        logic [2:0] nsf;
        logic [2:0] nst;
        logic [3:0] ctrl;
    } mword_t;

    logic        clk = 1'b0;
    logic        reset, en, cond, wr_en, busy;
    logic [1:0]  sel;
    logic [3:0]  ctrl;
    logic [2:0]  state, wr_addr;
    logic [11:0] wr_data;

    logic        go;
    logic [3:0]  a_in, a_reg, cnt;

    mword_t      m_store [8];
    logic [2:0]  m_state;

    int compared   = 0;
    int mismatched = 0;

    ucode_sequencer #(.ADDR_W(3), .CTRL_W(4)) dut (
        .clk(clk), .reset(reset), .en(en), .cond(cond), .sel(sel), .ctrl(ctrl),
        .state(state), .busy(busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    // External 4:1 condition mux: go / done / ax / one.
    assign cond = (sel == 2'b00) ? go :
                  (sel == 2'b01) ? (a_reg == 4'd0) :
                  (sel == 2'b10) ? a_reg[0] : 1'b1;

    // Count-ones datapath steered by the control word.
    always @(posedge clk) begin
        if (!reset && en) begin
            if (ctrl[0]) begin
                a_reg <= a_in;
                cnt   <= 4'd0;
            end else if (ctrl[1]) begin
                a_reg <= a_reg >> 1;
            end
            if (ctrl[2]) cnt <= cnt + 4'd1;
        end
    end

    function automatic mword_t def_word(input int i);
        case (i)
            0: return '{sel: 2'b00, nsf: 3'd0, nst: 3'd1, ctrl: 4'b0000};
            1: return '{sel: 2'b11, nsf: 3'd1, nst: 3'd2, ctrl: 4'b0001};
            2: return '{sel: 2'b01, nsf: 3'd3, nst: 3'd5, ctrl: 4'b0000};
            3: return '{sel: 2'b10, nsf: 3'd4, nst: 3'd6, ctrl: 4'b0000};
            4: return '{sel: 2'b11, nsf: 3'd2, nst: 3'd2, ctrl: 4'b0010};
            5: return '{sel: 2'b00, nsf: 3'd0, nst: 3'd5, ctrl: 4'b1000};
            6: return '{sel: 2'b11, nsf: 3'd4, nst: 3'd4, ctrl: 4'b0100};
            default: return '{sel: 2'b11, nsf: 3'd0, nst: 3'd0, ctrl: 4'b0000};
        endcase
    endfunction

    function automatic logic mux_f(input logic [1:0] s);
        case (s)
            2'b00:   return go;
            2'b01:   return (a_reg == 4'd0);
            2'b10:   return a_reg[0];
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [9:0] exp_vec();
        return {m_state, m_store[m_state].sel, m_store[m_state].ctrl, (m_state != 3'd0)};
    endfunction

    // Advance one clock, updating the model from the pre-edge condition.
    task automatic tick();
        logic       c;
        logic [2:0] nxt;
        c   = mux_f(m_store[m_state].sel);
        nxt = c ? m_store[m_state].nst : m_store[m_state].nsf;
        @(posedge clk);
        if (reset) begin
            m_state = 3'd0;
            for (int i = 0; i < 8; i++) m_store[i] = def_word(i);
        end else begin
            if (en)    m_state = nxt;
            if (wr_en) m_store[wr_addr] = mword_t'(wr_data);
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; wr_en = 1'b0; go = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; wr_en = 1'b1; wr_addr = 3'd0;
        wr_data = 12'($urandom); go = 1'b1; a_in = 4'd0;
        tick();
        tick();
        compared++;
        if ({state, sel, ctrl, busy} !== 10'd0) begin
            mismatched++;
            $display("FAIL reset_out: got state=%0d sel=%0d ctrl=%b busy=%0d, want all zero", state, sel, ctrl, busy);
        end
        reset = 1'b0; wr_en = 1'b0; go = 1'b0; en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            compared++;
            if ({state, sel, ctrl, busy} !== 10'd0 || {state, sel, ctrl, busy} !== exp_vec()) begin
                mismatched++;
                $display("FAIL idle_go0 cyc%0d: got state=%0d sel=%0d ctrl=%b busy=%0d, want idle", k, state, sel, ctrl, busy);
            end
        end
    endtask

    task automatic test_sequence();
        int seq [19] = '{0, 1, 2, 3, 6, 4, 2, 3, 6, 4, 2, 3, 4, 2, 3, 6, 4, 2, 5};
        int incs = 0;
        do_reset();
        en = 1'b1; a_in = 4'b1011; go = 1'b1;
        for (int k = 1; k < 19; k++) begin
            tick();
            if (ctrl[2]) incs++;
            compared++;
            if (state !== 3'(seq[k]) || {state, sel, ctrl, busy} !== exp_vec()) begin
                mismatched++;
                $display("FAIL seq step%0d: got state=%0d sel=%0d ctrl=%b, want state=%0d", k, state, sel, ctrl, seq[k]);
            end
        end
        compared++;
        if (incs !== 3 || ctrl[3] !== 1'b1 || cnt !== 4'd3) begin
            mismatched++;
            $display("FAIL seq_result: got incs=%0d dn=%0d cnt=%0d, want 3 1 3", incs, ctrl[3], cnt);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            compared++;
            if (state !== 3'd5 || ctrl[3] !== 1'b1) begin
                mismatched++;
                $display("FAIL done_hold cyc%0d: got state=%0d dn=%0d, want 5 1", k, state, ctrl[3]);
            end
        end
        go = 1'b0;
        tick();
        compared++;
        if (state !== 3'd0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL done_release: got state=%0d busy=%0d, want 0 0", state, busy);
        end
    endtask

    task automatic test_enable_hold();
        int n = 0;
        do_reset();
        en = 1'b1; a_in = 4'b1011; go = 1'b1;
        while (state !== 3'd3 && n < 10) begin tick(); n++; end
        compared++;
        if (state !== 3'd3) begin
            mismatched++;
            $display("FAIL hold_reach3: got state=%0d after %0d cycles, want 3", state, n);
        end
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            compared++;
            if (state !== 3'd3 || ctrl !== 4'b0000 || {state, sel, ctrl, busy} !== exp_vec()) begin
                mismatched++;
                $display("FAIL hold_frozen cyc%0d: got state=%0d ctrl=%b, want 3 0000", k, state, ctrl);
            end
        end
        en = 1'b1;
        tick();
        compared++;
        if (state !== 3'd6) begin
            mismatched++;
            $display("FAIL hold_resume: got state=%0d, want 6", state);
        end
        n = 0;
        while (state !== 3'd5 && n < 40) begin tick(); n++; end
        compared++;
        if (state !== 3'd5 || cnt !== 4'd3) begin
            mismatched++;
            $display("FAIL hold_finish: got state=%0d cnt=%0d, want 5 3", state, cnt);
        end
    endtask

    task automatic test_reset_midrun();
        int n = 0;
        do_reset();
        en = 1'b1; a_in = 4'b1011; go = 1'b1;
        while (state !== 3'd6 && n < 10) begin tick(); n++; end
        reset = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 12'hFFF;
        tick();
        reset = 1'b0; wr_en = 1'b0;
        compared++;
        if ({state, sel, ctrl, busy} !== 10'd0 || n >= 10) begin
            mismatched++;
            $display("FAIL midrun_reset: got state=%0d sel=%0d ctrl=%b busy=%0d (reach=%0d), want idle", state, sel, ctrl, busy, n);
        end
        tick();
        compared++;
        if (state !== 3'd1 || {state, sel, ctrl, busy} !== exp_vec()) begin
            mismatched++;
            $display("FAIL midrun_entry0: got state=%0d ctrl=%b, want 1 0001", state, ctrl);
        end
    endtask

    task automatic test_write_current();
        int n = 0;
        do_reset();
        en = 1'b1; a_in = 4'b1011; go = 1'b1;
        while (state !== 3'd2 && n < 10) begin tick(); n++; end
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 12'b11_000_111_0000;
        tick();
        wr_en = 1'b0;
        compared++;
        if (state !== 3'd3) begin
            mismatched++;
            $display("FAIL wr_old_word: got state=%0d, want 3", state);
        end
        n = 0;
        while (state !== 3'd2 && n < 10) begin tick(); n++; end
        tick();
        compared++;
        if (state !== 3'd7 || {state, sel, ctrl, busy} !== exp_vec()) begin
            mismatched++;
            $display("FAIL wr_new_word: got state=%0d, want 7", state);
        end
        tick();
        compared++;
        if (state !== 3'd0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL wr_trap: got state=%0d busy=%0d, want 0 0", state, busy);
        end
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 20; it++) begin
            do_reset();
            a_in = 4'($urandom); go = 1'b1; n = 0;
            while (m_state !== 3'd5 && n < 300) begin
                en      = ($urandom_range(0, 3) != 0);
                wr_en   = ($urandom_range(0, 4) == 0);
                wr_addr = 3'd7;
                wr_data = 12'($urandom);
                tick();
                n++;
                compared++;
                if ({state, sel, ctrl, busy} !== exp_vec()) begin
                    mismatched++;
                    $display("FAIL rand it%0d cyc%0d: got %b, want %b", it, n, {state, sel, ctrl, busy}, exp_vec());
                end
            end
            wr_en = 1'b0;
            compared++;
            if (state !== 3'd5 || cnt !== 4'($countones(a_in))) begin
                mismatched++;
                $display("FAIL rand_count it%0d a=%b: got state=%0d cnt=%0d, want 5 %0d", it, a_in, state, cnt, $countones(a_in));
            end
            go = 1'b0; en = 1'b1;
            tick();
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 12'd0;
        go = 1'b0; a_in = 4'd0; m_state = 3'd0;
        test_reset();
        test_sequence();
        test_enable_hold();
        test_reset_midrun();
        test_write_current();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
